capture_bank: RTL

- Parametrised multi-channel successor to the single-register write-enable capture block.
- A free-running counter is sampled into one of NUM_CH write-enabled registers on a start request.
- Single mode writes one selected channel; burst mode fills consecutive channels on consecutive cycles.
- Sits between control logic issuing start and downstream readers of q/valid; also serves as the test vehicle for write-enable storage.

---
 rtl/capture_bank_pkg.sv | 15 +
 rtl/capture_reg.sv | 24 ++
 rtl/capture_bank.sv | 119 +++++++++++
 3 files changed

// File: rtl/capture_bank_pkg.sv
// Shared types for the capture_bank block: FSM state and capture mode encodings.
package capture_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    BURST = 2'd2
  } state_t;

  typedef enum logic {
    MODE_SINGLE = 1'b0,
    MODE_BURST  = 1'b1
  } mode_t;

endpackage

// File: rtl/capture_reg.sv
// One write-enabled capture register; holds its value until the next enabled write.
module capture_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else if (we_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/capture_bank.sv
// Multi-channel counter capture bank with single and burst write modes.
// Build option CAPTURE_BANK_SAT_COUNT_EN: saturating counter cleared on each write (interval mode).
module capture_bank
  import capture_bank_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_CH = 4,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mode,
  input  logic [CH_W-1:0]         ch_sel,
  input  logic                    clr_valid,
  output logic [WIDTH-1:0]        count,
  output logic [NUM_CH*WIDTH-1:0] q,
  output logic [NUM_CH-1:0]       valid,
  output logic                    busy,
  output logic                    done
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [NUM_CH-1:0] valid_q, valid_d;
  logic [NUM_CH-1:0] ch_we;
  logic              we_c;
  logic              sel_ok;

  assign sel_ok = (32'(ch_sel) < NUM_CH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      done_q  <= 1'b0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Next-state: WRITE is a single-cycle write, BURST walks ptr up to the last channel.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    we_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && sel_ok) begin
          ptr_d   = ch_sel;
          state_d = (mode_t'(mode) == MODE_BURST) ? BURST : WRITE;
        end
      end
      WRITE: begin
        we_c    = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      BURST: begin
        we_c = 1'b1;
        if (ptr_q == LAST_CH) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          ptr_d = ptr_q + CH_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CAPTURE_BANK_SAT_COUNT_EN
  // Interval counter: restarts at every write, sticks at all-ones.
  always_comb begin
    count_d = count_q;
    if (we_c) begin
      count_d = '0;
    end else if (count_q != {WIDTH{1'b1}}) begin
      count_d = count_q + WIDTH'(1);
    end
  end
`else
  assign count_d = count_q + WIDTH'(1);
`endif

  // Write wins over a simultaneous clear for the channel being written.
  assign valid_d = (clr_valid ? {NUM_CH{1'b0}} : valid_q) | ch_we;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_we[i] = we_c && (ptr_q == CH_W'(i));

    capture_reg #(
      .WIDTH(WIDTH)
    ) u_reg (
      .clk_i(clk),
      .rst_i(rst),
      .we_i (ch_we[i]),
      .d_i  (count_q),
      .q_o  (q[i*WIDTH +: WIDTH])
    );
  end

  assign count = count_q;
  assign valid = valid_q;
  assign done  = done_q;
  assign busy  = (state_q != IDLE);

endmodule
